// File: rtl/fir_out_requant.sv
// fir_out_requant
//   Output stage for the FIR filters. Each kept sample (1 of every DEC valid
//   inputs) is rounded half-up by an arithmetic right shift of SHIFT bits,
//   saturated to OUT_W signed bits and pushed into a small FWFT FIFO. The FIFO
//   drains through a valid/ready handshake toward the DAC/capture logic.
//   Saturation and FIFO-full drops are counted for debug.
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active low
//   din         signed FIR result, IN_W bits
//   din_valid   din qualifier
//   dout        signed requantized sample at the FIFO head (0 while empty)
//   dout_valid  FIFO non-empty
//   dout_ready  consumer accepts dout when dout_valid && dout_ready
//   fifo_level  FIFO occupancy
//   sat_flag    sticky: some kept sample saturated
//   sat_cnt     saturated-sample count, holds at 16'hFFFF
//   drop_cnt    samples lost to a full FIFO, holds at 16'hFFFF
module fir_out_requant #(
    parameter int IN_W       = 29,
    parameter int OUT_W      = 12,
    parameter int SHIFT      = 12,
    parameter int DEC        = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IN_W-1:0]               din,
    input  logic                          din_valid,
    output logic [OUT_W-1:0]              dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          sat_flag,
    output logic [15:0]                   sat_cnt,
    output logic [15:0]                   drop_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int PH_W  = (DEC > 1) ? $clog2(DEC) : 1;
    // Half an LSB of the output grid; zero when SHIFT==0 so the value passes through.
    localparam logic signed [IN_W:0] RND    = (IN_W+1)'((2**SHIFT) / 2);
    localparam logic signed [IN_W:0] SAT_HI = (IN_W+1)'((2**(OUT_W-1)) - 1);
    localparam logic signed [IN_W:0] SAT_LO = -SAT_HI - 1;

    logic [PH_W-1:0]  phase_q, phase_d;
    logic [IN_W-1:0]  s1_q, s1_d;
    logic             s1_vld_q, s1_vld_d;
    logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
    logic [OUT_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             sat_flag_q, sat_flag_d;
    logic [15:0]      sat_cnt_q, sat_cnt_d, drop_cnt_q, drop_cnt_d;

    logic signed [IN_W:0] sum, q;
    logic [OUT_W-1:0]     res;
    logic                 keep, clip, rd, full, wr_ok, drop;

    always_comb begin
        // Decimation: phase only moves on valid input, sample kept at phase 0.
        keep    = din_valid && (phase_q == '0);
        phase_d = phase_q;
        if (din_valid) begin
            phase_d = (phase_q == PH_W'(DEC - 1)) ? '0 : phase_q + PH_W'(1);
        end
        s1_d     = keep ? din : s1_q;
        s1_vld_d = keep;

        // Round half-up in IN_W+1 bits so the +RND cannot wrap, then shift.
        sum  = $signed({s1_q[IN_W-1], s1_q}) + RND;
        q    = sum >>> SHIFT;
        clip = 1'b0;
        res  = q[OUT_W-1:0];
        if (q > SAT_HI) begin
            clip = 1'b1;
            res  = SAT_HI[OUT_W-1:0];
        end else if (q < SAT_LO) begin
            clip = 1'b1;
            res  = SAT_LO[OUT_W-1:0];
        end

        // A read frees the head slot in the same edge, so full+read still accepts.
        rd    = (level_q != '0) && dout_ready;
        full  = (level_q == (PTR_W+1)'(FIFO_DEPTH));
        wr_ok = s1_vld_q && (!full || rd);
        drop  = s1_vld_q && full && !rd;

        mem_d = mem_q;
        if (wr_ok) mem_d[wr_ptr_q] = res;
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd);
        case ({wr_ok, rd})
            2'b10:   level_d = level_q + (PTR_W+1)'(1);
            2'b01:   level_d = level_q - (PTR_W+1)'(1);
            default: level_d = level_q;
        endcase

        // Saturation is counted even when the sample is then dropped.
        sat_flag_d = sat_flag_q;
        sat_cnt_d  = sat_cnt_q;
        if (s1_vld_q && clip) begin
            sat_flag_d = 1'b1;
            if (sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
        end
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q    <= '0;
            s1_q       <= '0;
            s1_vld_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sat_flag_q <= 1'b0;
            sat_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            phase_q    <= phase_d;
            s1_q       <= s1_d;
            s1_vld_q   <= s1_vld_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            sat_flag_q <= sat_flag_d;
            sat_cnt_q  <= sat_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign dout_valid = (level_q != '0);
    // Head slot may hold stale data after reset; present 0 whenever empty.
    assign dout       = dout_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign sat_flag   = sat_flag_q;
    assign sat_cnt    = sat_cnt_q;
    assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_fir_out_requant.sv
module tb_fir_out_requant;
    logic        clk = 1'b0;
    logic        rst;
    logic [28:0] din;
    logic        din_valid;
    logic [11:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [2:0]  fifo_level;
    logic        sat_flag;
    logic [15:0] sat_cnt;
    logic [15:0] drop_cnt;

    int          nchk = 0;
    int          npass = 0;
    logic [11:0] exp_q[$];
    int          tb_phase = 0;
    bit          expect_drop = 1'b0;
    logic [11:0] head_exp;

    fir_out_requant #(.IN_W(29), .OUT_W(12), .SHIFT(12), .DEC(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .fifo_level(fifo_level), .sat_flag(sat_flag), .sat_cnt(sat_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference: round half-up then divide by 4096 with floor, clamp to 12 bits.
    function automatic logic [11:0] model(input int v);
        longint t, qv;
        t = longint'(v) + 2048;
        if (t >= 0) qv = t / 4096;
        else        qv = -((-t + 4095) / 4096);
        if (qv > 2047)  qv = 2047;
        if (qv < -2048) qv = -2048;
        return qv[11:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // One clock of input; the bench tracks decimation phase to know what is kept.
    task automatic drv(input int v, input bit vld);
        din = v[28:0];
        din_valid = vld;
        @(posedge clk); #1;
        if (vld) begin
            if (tb_phase == 0 && !expect_drop) exp_q.push_back(model(v));
            tb_phase = (tb_phase + 1) % 4;
        end
        din_valid = 1'b0;
    endtask

    task automatic kept(input int v);
        drv(v, 1'b1);
        for (int i = 0; i < 3; i++) drv(0, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: every accepted output must match the oldest expected sample.
    always @(negedge clk) begin
        if (rst && dout_valid && dout_ready) begin
            nchk++;
            if (exp_q.size() == 0) begin
                $error("FAIL pop_unexpected observed=%0h expected=none", dout);
            end else begin
                head_exp = exp_q.pop_front();
                assert (dout === head_exp) npass++;
                else $error("FAIL dout_seq observed=%0h expected=%0h", dout, head_exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst = 1'b1;

        // Rounding and two-edge latency.
        dout_ready = 1'b1;
        drv(6144, 1'b1);
        chk("lat_not_yet", dout_valid, 0);
        drv(0, 1'b1);
        chk("lat_valid", dout_valid, 1);
        chk("lat_dout", dout, 12'h002);
        drv(0, 1'b1); drv(0, 1'b1);
        kept(-6144);
        kept(2047);
        kept(2048);
        wait_drain("round_drain");

        // Saturation both ways.
        kept(1 << 27);
        kept(-(1 << 27));
        wait_drain("sat_drain");
        chk("sat_cnt", sat_cnt, 2);
        chk("sat_flag", sat_flag, 1);

        // Decimation with continuous valid: kept n = 0,4,8,12.
        for (int n = 0; n < 16; n++) drv(n << 12, 1'b1);
        wait_drain("dec_cont_drain");
        // Sparse valid: phase must ignore idle cycles, kept n = 0,4.
        for (int n = 0; n < 8; n++) begin
            drv(n << 12, 1'b1);
            for (int i = 0; i < 7; i++) drv(12345, 1'b0);
        end
        wait_drain("dec_sparse_drain");

        // Backpressure: 6 kept, last 2 dropped.
        dout_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            expect_drop = (k >= 4);
            kept((100 + k) << 12);
        end
        expect_drop = 1'b0;
        drv(0, 1'b0); drv(0, 1'b0);
        chk("bp_level", fifo_level, 4);
        chk("bp_drop", drop_cnt, 2);
        chk("bp_valid", dout_valid, 1);
        chk("bp_head_stable", dout, 12'd100);
        dout_ready = 1'b1;
        wait_drain("bp_drain");
        drv(0, 1'b0);
        chk("bp_empty", dout_valid, 0);

        // Full FIFO with read and write at the same edge.
        dout_ready = 1'b0;
        for (int k = 0; k < 4; k++) kept((200 + k) << 12);
        chk("rw_full", fifo_level, 4);
        drv(204 << 12, 1'b1);      // s1 now holds a kept sample
        dout_ready = 1'b1;
        drv(0, 1'b1);              // write and read share this edge
        dout_ready = 1'b0;
        chk("rw_level", fifo_level, 4);
        chk("rw_drop", drop_cnt, 2);
        drv(0, 1'b1); drv(0, 1'b1);
        dout_ready = 1'b1;
        wait_drain("rw_drain");

        // Reset mid-stream with level 3 and s1 valid.
        dout_ready = 1'b0;
        for (int k = 0; k < 3; k++) kept((300 + k) << 12);
        drv(303 << 12, 1'b1);
        chk("mid_level", fifo_level, 3);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        tb_phase = 0;
        chk("mid_valid", dout_valid, 0);
        chk("mid_level0", fifo_level, 0);
        chk("mid_dout", dout, 0);
        chk("mid_sat_cnt", sat_cnt, 0);
        chk("mid_sat_flag", sat_flag, 0);
        chk("mid_drop", drop_cnt, 0);
        drv(0, 1'b0);
        chk("mid_no_stale", dout_valid, 0);
        dout_ready = 1'b1;
        drv(7 << 12, 1'b1);
        drv(0, 1'b0);
        chk("post_rst_kept", dout_valid, 1);
        wait_drain("post_rst_drain");

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
